// File: rtl/k501_pkg.sv
// Shared types and defaults for the K501 CPU/video RAM bus arbiter.
package k501_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    ACCESS    = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [1:0] SLOT_PHASE_DEF = 2'd3;
  localparam int         DATA_W_DEF     = 8;

endpackage

// File: rtl/k501_bus_arbiter.sv
// Grants the Z80 one pixel phase in four on the shared RAM bus, stalling it
// with WAIT until its slot arrives and latching read data at the end of access.
module k501_bus_arbiter
  import k501_pkg::*;
#(
  parameter logic [1:0] SLOT_PHASE = SLOT_PHASE_DEF,
  parameter int         SLOT_LEN   = 1,
  parameter int         DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CEN,
  input  logic [1:0]        H,
  input  logic              MREQ,
  input  logic              RFSH,
  input  logic              RD,
  input  logic              WR,
  input  logic              K501_SEL,
  input  logic [DATA_W-1:0] CPU_DIN,
  input  logic [DATA_W-1:0] RAM_DOUT,
  output logic              ENABLE,
  output logic              WAIT,
  output logic              RAM_WE,
  output logic [DATA_W-1:0] RAM_DIN,
  output logic [DATA_W-1:0] CPU_DOUT,
  output state_t            fsm_state
);

  localparam logic [1:0] CNT_LOAD = 2'(SLOT_LEN - 1);

  // Handshake: req is the CPU's valid; WAIT low is the not-ready stall. The
  // CPU holds its bus cycle until WAIT rises, which happens only in DONE.
  logic req;
  assign req = ~MREQ & RFSH & ~K501_SEL & (~RD | ~WR);

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic              wr_lat, wr_lat_nxt;
  logic [DATA_W-1:0] ram_din_q, ram_din_nxt;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_nxt;
  logic              slot;

  assign slot = (H == SLOT_PHASE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      wr_lat     <= 1'b0;
      ram_din_q  <= '0;
      cpu_dout_q <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wr_lat     <= wr_lat_nxt;
      ram_din_q  <= ram_din_nxt;
      cpu_dout_q <= cpu_dout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    wr_lat_nxt   = wr_lat;
    ram_din_nxt  = ram_din_q;
    cpu_dout_nxt = cpu_dout_q;
    if (CEN) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (slot) begin
              state_nxt   = ACCESS;
              cnt_nxt     = CNT_LOAD;
              wr_lat_nxt  = ~WR;
              ram_din_nxt = CPU_DIN;
            end else begin
              state_nxt = WAIT_SLOT;
            end
          end
        end
        WAIT_SLOT: begin
          // A dropped request beats a slot arriving on the same tick.
          if (!req) begin
            state_nxt = IDLE;
          end else if (slot) begin
            state_nxt   = ACCESS;
            cnt_nxt     = CNT_LOAD;
            wr_lat_nxt  = ~WR;
            ram_din_nxt = CPU_DIN;
          end
        end
        ACCESS: begin
          if (!req) begin
            state_nxt = IDLE;
          end else if (cnt == 2'd0) begin
            state_nxt = DONE;
            if (!wr_lat) cpu_dout_nxt = RAM_DOUT;
          end else begin
            cnt_nxt = cnt - 2'd1;
          end
        end
        DONE: begin
          if (!req) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Reset gates the strobes directly so no write extends past the reset edge.
  assign ENABLE    = ~((state == ACCESS) & ~reset);
  assign RAM_WE    = ~((state == ACCESS) & wr_lat & ~reset);
  assign WAIT      = ~(req & (state != DONE) & ~reset);
  assign RAM_DIN   = ram_din_q;
  assign CPU_DOUT  = cpu_dout_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_k501_bus_arbiter.sv
// Directed bench for k501_bus_arbiter: one instance with SLOT_LEN=1 and one
// with SLOT_LEN=3 share stimulus; each test checks the instance it targets.
module tb_k501_bus_arbiter;
  import k501_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       CEN;
  logic [1:0] H;
  logic       MREQ, RFSH, RD, WR, K501_SEL;
  logic [7:0] CPU_DIN, RAM_DOUT;

  logic       enable_a, wait_a, ram_we_a;
  logic [7:0] ram_din_a, cpu_dout_a;
  state_t     state_a;
  logic       enable_b, wait_b, ram_we_b;
  logic [7:0] ram_din_b, cpu_dout_b;
  state_t     state_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  k501_bus_arbiter #(.SLOT_PHASE(2'd3), .SLOT_LEN(1), .DATA_W(8)) dut_a (
    .clk(clk), .reset(reset), .CEN(CEN), .H(H), .MREQ(MREQ), .RFSH(RFSH),
    .RD(RD), .WR(WR), .K501_SEL(K501_SEL), .CPU_DIN(CPU_DIN), .RAM_DOUT(RAM_DOUT),
    .ENABLE(enable_a), .WAIT(wait_a), .RAM_WE(ram_we_a), .RAM_DIN(ram_din_a),
    .CPU_DOUT(cpu_dout_a), .fsm_state(state_a)
  );

  k501_bus_arbiter #(.SLOT_PHASE(2'd3), .SLOT_LEN(3), .DATA_W(8)) dut_b (
    .clk(clk), .reset(reset), .CEN(CEN), .H(H), .MREQ(MREQ), .RFSH(RFSH),
    .RD(RD), .WR(WR), .K501_SEL(K501_SEL), .CPU_DIN(CPU_DIN), .RAM_DOUT(RAM_DOUT),
    .ENABLE(enable_b), .WAIT(wait_b), .RAM_WE(ram_we_b), .RAM_DIN(ram_din_b),
    .CPU_DOUT(cpu_dout_b), .fsm_state(state_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CEN period: a CEN clk followed by a frozen clk; H advances after the CEN edge.
  task automatic step();
    CEN = 1'b1;
    @(negedge clk);
    CEN = 1'b0;
    H = H + 2'd1;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [7:0] data);
    MREQ = 1'b0; RD = 1'b0; WR = 1'b1; K501_SEL = 1'b0; RAM_DOUT = data;
  endtask

  task automatic cpu_write(input logic [7:0] data);
    MREQ = 1'b0; RD = 1'b1; WR = 1'b0; K501_SEL = 1'b0; CPU_DIN = data;
  endtask

  task automatic cpu_release();
    MREQ = 1'b1; RD = 1'b1; WR = 1'b1; K501_SEL = 1'b1;
  endtask

  initial begin
    reset = 1'b1; CEN = 1'b0; H = 2'd0; RFSH = 1'b1;
    CPU_DIN = 8'h00; RAM_DOUT = 8'h00;
    cpu_release();
    repeat (3) @(negedge clk);

    // Reset state, including WAIT overriding a live request.
    check("rst_state", state_a, IDLE);
    check("rst_enable", enable_a, 1'b1);
    check("rst_ram_we", ram_we_a, 1'b1);
    check("rst_cpu_dout", cpu_dout_a, 8'h00);
    check("rst_ram_din", ram_din_a, 8'h00);
    cpu_read(8'h00);
    #1;
    check("rst_wait_override", wait_a, 1'b1);
    cpu_release();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: read hit at slot.
    H = 2'd3;
    cpu_read(8'hA5);
    #1;
    check("t1_wait_comb", wait_a, 1'b0);
    @(negedge clk);
    step();
    check("t1_access_state", state_a, ACCESS);
    check("t1_enable_low", enable_a, 1'b0);
    check("t1_ram_we_read", ram_we_a, 1'b1);
    check("t1_wait_in_access", wait_a, 1'b0);
    step();
    check("t1_done_state", state_a, DONE);
    check("t1_enable_high", enable_a, 1'b1);
    check("t1_cpu_dout", cpu_dout_a, 8'hA5);
    check("t1_wait_done", wait_a, 1'b1);
    cpu_release();
    step();
    check("t1_idle", state_a, IDLE);

    // Test 2: write waiting for the slot, with a CEN freeze inside WAIT_SLOT.
    H = 2'd0;
    cpu_write(8'h3C);
    #1;
    check("t2_wait_comb", wait_a, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_wait_slot_state", state_a, WAIT_SLOT);
      check("t2_wait_slot_enable", enable_a, 1'b1);
      check("t2_wait_slot_wait", wait_a, 1'b0);
    end
    repeat (3) @(negedge clk);
    check("t2_freeze_state", state_a, WAIT_SLOT);
    check("t2_freeze_enable", enable_a, 1'b1);
    step();
    CPU_DIN = 8'hFF;
    #1;
    check("t2_access_enable", enable_a, 1'b0);
    check("t2_access_ram_we", ram_we_a, 1'b0);
    check("t2_access_ram_din", ram_din_a, 8'h3C);
    @(negedge clk);
    step();
    check("t2_done_enable", enable_a, 1'b1);
    check("t2_done_ram_we", ram_we_a, 1'b1);
    check("t2_done_wait", wait_a, 1'b1);
    check("t2_no_read_latch", cpu_dout_a, 8'hA5);
    cpu_release();
    step();

    // Test 3: refresh cycles never form a request.
    MREQ = 1'b0; RFSH = 1'b0; K501_SEL = 1'b0; RD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t3_enable", enable_a, 1'b1);
      check("t3_ram_we", ram_we_a, 1'b1);
      check("t3_wait", wait_a, 1'b1);
    end
    check("t3_state", state_a, IDLE);
    RFSH = 1'b1;
    cpu_release();
    step();

    // Test 4: abort while waiting, then abort coinciding with slot arrival.
    H = 2'd1;
    cpu_read(8'h77);
    @(negedge clk);
    step();
    check("t4_wait_slot", state_a, WAIT_SLOT);
    cpu_release();
    #1;
    check("t4_wait_released", wait_a, 1'b1);
    @(negedge clk);
    step();
    check("t4_abort_idle", state_a, IDLE);
    check("t4_abort_enable", enable_a, 1'b1);
    H = 2'd1;
    cpu_read(8'h77);
    @(negedge clk);
    step();
    step();
    check("t4b_wait_slot", state_a, WAIT_SLOT);
    check("t4b_h_at_slot", H, 2'd3);
    cpu_release();
    @(negedge clk);
    step();
    check("t4b_abort_wins", state_a, IDLE);
    check("t4b_enable", enable_a, 1'b1);
    check("t4b_cpu_dout", cpu_dout_a, 8'hA5);

    // Test 5: reset on the second ACCESS tick of a SLOT_LEN=3 write.
    H = 2'd3;
    cpu_write(8'h5A);
    @(negedge clk);
    step();
    check("t5_b_access_enable", enable_b, 1'b0);
    check("t5_b_access_ram_we", ram_we_b, 1'b0);
    step();
    check("t5_b_still_access", state_b, ACCESS);
    check("t5_b_ram_din", ram_din_b, 8'h5A);
    reset = 1'b1;
    @(negedge clk);
    check("t5_b_enable", enable_b, 1'b1);
    check("t5_b_ram_we", ram_we_b, 1'b1);
    check("t5_b_wait", wait_b, 1'b1);
    check("t5_b_state", state_b, IDLE);
    check("t5_b_ram_din_clr", ram_din_b, 8'h00);
    check("t5_a_cpu_dout_clr", cpu_dout_a, 8'h00);
    cpu_release();
    reset = 1'b0;
    @(negedge clk);

    // Test 6: back-to-back reads, one access per Z80 cycle.
    H = 2'd1;
    cpu_read(8'h11);
    @(negedge clk);
    step();
    step();
    step();
    check("t6_first_access", enable_a, 1'b0);
    step();
    check("t6_first_dout", cpu_dout_a, 8'h11);
    check("t6_first_wait", wait_a, 1'b1);
    RAM_DOUT = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_hold_done", state_a, DONE);
      check("t6_no_double", enable_a, 1'b1);
    end
    check("t6_hold_dout", cpu_dout_a, 8'h11);
    cpu_release();
    step();
    check("t6_gap_idle", state_a, IDLE);
    cpu_read(8'h22);
    @(negedge clk);
    step();
    check("t6_second_wait_slot", state_a, WAIT_SLOT);
    check("t6_second_wait", wait_a, 1'b0);
    step();
    check("t6_second_access", enable_a, 1'b0);
    step();
    check("t6_second_dout", cpu_dout_a, 8'h22);
    cpu_release();
    step();

    // Test 7: SLOT_LEN=3 read, then a read aborted mid-ACCESS.
    H = 2'd3;
    cpu_read(8'h99);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_b_access", enable_b, 1'b0);
      check("t7_b_wait", wait_b, 1'b0);
    end
    step();
    check("t7_b_done", state_b, DONE);
    check("t7_b_dout", cpu_dout_b, 8'h99);
    check("t7_b_enable", enable_b, 1'b1);
    cpu_release();
    step();
    H = 2'd3;
    cpu_read(8'h66);
    @(negedge clk);
    step();
    step();
    check("t7_b_mid_access", state_b, ACCESS);
    cpu_release();
    @(negedge clk);
    step();
    check("t7_b_abort_idle", state_b, IDLE);
    check("t7_b_abort_enable", enable_b, 1'b1);
    check("t7_b_no_latch", cpu_dout_b, 8'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
